// File: rtl/mask_seq_pkg.sv
// Shared types and constants for the mask stream sequencer.
// Maps the resolution select to the number of serializer beats per mask.
package mask_seq_pkg;
  localparam int OP_CHANNEL_WIDTH = 20;
  localparam int STEPS_RES0       = 16;
  localparam int STEPS_RES1       = 32;
  localparam int STEPS_RES2       = 54;
  localparam int MASK_CNT_W       = 10;
  localparam int BEAT_W           = 6;

  typedef enum logic [1:0] {IDLE, WAIT_GEN, LOAD, STREAM} seq_state_t;

  localparam logic [1:0] RES_320  = 2'd0;
  localparam logic [1:0] RES_640  = 2'd1;
  localparam logic [1:0] RES_1080 = 2'd2;

  // The unused code 3 falls back to the 640 setting.
  function automatic logic [BEAT_W-1:0] steps_for_res(input logic [1:0] res);
    case (res)
      RES_320:  return BEAT_W'(STEPS_RES0);
      RES_1080: return BEAT_W'(STEPS_RES2);
      default:  return BEAT_W'(STEPS_RES1);
    endcase
  endfunction
endpackage

// File: rtl/beat_counter.sv
// Per-mask beat counter with a latched terminal count.
// last_beat is high while the next accepted beat completes the mask.
module beat_counter
  import mask_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_steps,
  input  logic [BEAT_W-1:0] steps_in,
  input  logic              clear,
  input  logic              en,
  output logic              last_beat
);
  logic [BEAT_W-1:0] steps_q;
  logic [BEAT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      steps_q <= BEAT_W'(STEPS_RES1);
      cnt     <= '0;
    end else begin
      if (load_steps) steps_q <= steps_in;
      if (clear)      cnt <= '0;
      else if (en)    cnt <= cnt + BEAT_W'(1);
    end
  end

  assign last_beat = (cnt == steps_q - BEAT_W'(1));
endmodule

// File: rtl/mask_stream_sequencer.sv
// Frame sequencer: gates the mask generator, loads the serializer, paces beats
// against sink readiness and checks the serializer's done timing.
module mask_stream_sequencer
  import mask_seq_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [MASK_CNT_W-1:0] num_masks,
  input  logic [1:0]            image_resolution,
  input  logic                  gen_valid,
  output logic                  gen_en,
  output logic                  ser_load,
  output logic                  ser_next,
  input  logic                  ser_done,
  input  logic                  sink_ready,
  output logic                  beat_valid,
  output logic                  busy,
  output logic                  frame_done,
  output logic [MASK_CNT_W-1:0] mask_idx,
  output logic                  err
);
  seq_state_t            state;
  logic [MASK_CNT_W-1:0] last_idx;
  logic [1:0]            done_wait;
  logic                  last_beat;
  logic                  take_start;
  logic                  final_beat;

  assign take_start = (state == IDLE) && start && !abort;
  assign ser_next   = (state == STREAM) && sink_ready;
  assign beat_valid = ser_next;
  assign busy       = (state != IDLE);
  assign final_beat = ser_next && last_beat;
  assign frame_done = final_beat && (mask_idx == last_idx) && !abort;

  beat_counter u_beat_counter (
    .clk        (clk),
    .rst        (rst),
    .load_steps (take_start),
    .steps_in   (steps_for_res(image_resolution)),
    .clear      (state == LOAD),
    .en         (ser_next),
    .last_beat  (last_beat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gen_en    <= 1'b0;
      ser_load  <= 1'b0;
      mask_idx  <= '0;
      last_idx  <= '0;
      err       <= 1'b0;
      done_wait <= '0;
    end else begin
      gen_en   <= 1'b0;
      ser_load <= 1'b0;

      // ser_done must land on the last beat or within the two cycles after it.
      if (state == STREAM && ser_done && !final_beat) err <= 1'b1;
      if (done_wait != 2'd0) begin
        if (ser_done)                done_wait <= '0;
        else if (done_wait == 2'd1) begin
          err       <= 1'b1;
          done_wait <= '0;
        end else                     done_wait <= done_wait - 2'd1;
      end
      if (final_beat && !ser_done) done_wait <= 2'd2;

      if (abort) begin
        state     <= IDLE;
        done_wait <= '0;
      end else begin
        case (state)
          IDLE: if (start) begin
            last_idx  <= (num_masks == '0) ? '0 : num_masks - MASK_CNT_W'(1);
            mask_idx  <= '0;
            err       <= 1'b0;
            done_wait <= '0;
            gen_en    <= 1'b1;
            state     <= WAIT_GEN;
          end
          WAIT_GEN: if (gen_valid) begin
            ser_load <= 1'b1;
            state    <= LOAD;
          end else begin
            gen_en <= 1'b1;
          end
          LOAD: state <= STREAM;
          STREAM: if (final_beat) begin
            if (mask_idx == last_idx) begin
              state <= IDLE;
            end else begin
              mask_idx <= mask_idx + MASK_CNT_W'(1);
              gen_en   <= 1'b1;
              state    <= WAIT_GEN;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mask_stream_sequencer.sv
// Directed bench for mask_stream_sequencer with a small serializer model.
module tb_mask_stream_sequencer;
  logic       clk = 1'b0;
  logic       rst, start, abort, gen_valid, sink_ready, ser_done;
  logic [9:0] num_masks;
  logic [1:0] image_resolution;
  logic       gen_en, ser_load, ser_next, beat_valid, busy, frame_done, err;
  logic [9:0] mask_idx;

  int checks = 0;
  int errors = 0;

  // serializer model: counts beats since load, reports done on its last beat
  int m_cnt = 0;
  int m_steps = 32;
  int force_after = -1;
  bit auto_done = 1'b1;

  int r_beats, r_loads, r_fdone, r_fd_beat, r_gen_bad, r_lat_bad, r_nidx;
  bit r_timeout, r_busy_after;
  int r_idx [8];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ser_load)      m_cnt <= 0;
    else if (ser_next) m_cnt <= m_cnt + 1;
  end

  assign ser_done = (force_after >= 0 && m_cnt >= force_after) ||
                    (auto_done && ser_next && m_cnt == m_steps - 1);

  mask_stream_sequencer dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .abort            (abort),
    .num_masks        (num_masks),
    .image_resolution (image_resolution),
    .gen_valid        (gen_valid),
    .gen_en           (gen_en),
    .ser_load         (ser_load),
    .ser_next         (ser_next),
    .ser_done         (ser_done),
    .sink_ready       (sink_ready),
    .beat_valid       (beat_valid),
    .busy             (busy),
    .frame_done       (frame_done),
    .mask_idx         (mask_idx),
    .err              (err)
  );

  // Runs one frame with a responsive generator; gathers statistics only.
  task automatic run_frame(input logic [1:0] res, input logic [9:0] nm,
                           input bit toggle, input int gv_delay);
    int gcnt;
    bit gv_prev, fd_prev;
    r_beats = 0; r_loads = 0; r_fdone = 0; r_fd_beat = -1; r_gen_bad = 0;
    r_lat_bad = 0; r_nidx = 0; r_timeout = 1'b1; r_busy_after = 1'b1;
    gcnt = 0; gv_prev = 1'b0; fd_prev = 1'b0;
    @(posedge clk); #1;
    image_resolution = res; num_masks = nm; start = 1'b1;
    sink_ready = 1'b1; gen_valid = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (fd_prev) begin
        r_busy_after = busy;
        r_timeout = 1'b0;
        break;
      end
      gcnt = gen_en ? gcnt + 1 : 0;
      gen_valid = gen_en && (gcnt >= gv_delay);
      if (toggle) sink_ready = ~sink_ready;
      #1;
      if (gv_prev && !ser_load) r_lat_bad++;
      if (ser_load) begin
        if (!gv_prev) r_lat_bad++;
        if (r_nidx < 8) r_idx[r_nidx] = int'(mask_idx);
        r_nidx++;
        r_loads++;
      end
      if (gen_en && (ser_load || ser_next || !busy)) r_gen_bad++;
      if (beat_valid !== ser_next) r_gen_bad++;
      if (ser_next) r_beats++;
      if (frame_done) begin
        r_fdone++;
        r_fd_beat = r_beats;
      end
      gv_prev = gen_valid;
      fd_prev = frame_done;
    end
    gen_valid = 1'b0;
    sink_ready = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 0; abort = 0; gen_valid = 0; sink_ready = 1;
    num_masks = 0; image_resolution = 0;
    #12;
    checks++;
    if ({gen_en, ser_load, ser_next, beat_valid, busy, frame_done, err} !== 7'b0 ||
        mask_idx !== 10'd0) begin
      errors++;
      $display("FAIL reset_outputs got %b idx %0d exp 0", {gen_en, ser_load, ser_next,
               beat_valid, busy, frame_done, err}, mask_idx);
    end
    rst = 1'b0;
  endtask

  task automatic test_single;
    m_steps = 32;
    run_frame(2'd1, 10'd1, 1'b0, 3);
    checks++; if (r_timeout) begin errors++; $display("FAIL single_timeout"); end
    checks++; if (r_loads !== 1) begin errors++; $display("FAIL single_loads got %0d exp 1", r_loads); end
    checks++; if (r_lat_bad !== 0) begin errors++; $display("FAIL single_load_latency got %0d exp 0", r_lat_bad); end
    checks++; if (r_beats !== 32) begin errors++; $display("FAIL single_beats got %0d exp 32", r_beats); end
    checks++; if (r_fdone !== 1 || r_fd_beat !== 32) begin errors++; $display("FAIL single_frame_done got %0d@%0d exp 1@32", r_fdone, r_fd_beat); end
    checks++; if (r_busy_after !== 1'b0) begin errors++; $display("FAIL single_busy_after got %0d exp 0", r_busy_after); end
    checks++; if (err !== 1'b0 || r_gen_bad !== 0) begin errors++; $display("FAIL single_err_gen got %0d/%0d exp 0/0", err, r_gen_bad); end
  endtask

  task automatic test_multi_toggle;
    m_steps = 54;
    run_frame(2'd2, 10'd3, 1'b1, 1);
    checks++; if (r_timeout) begin errors++; $display("FAIL multi_timeout"); end
    checks++; if (r_beats !== 162) begin errors++; $display("FAIL multi_beats got %0d exp 162", r_beats); end
    checks++; if (r_loads !== 3) begin errors++; $display("FAIL multi_loads got %0d exp 3", r_loads); end
    checks++; if (r_idx[0] !== 0 || r_idx[1] !== 1 || r_idx[2] !== 2) begin errors++; $display("FAIL multi_mask_idx got %0d,%0d,%0d exp 0,1,2", r_idx[0], r_idx[1], r_idx[2]); end
    checks++; if (r_fdone !== 1 || r_fd_beat !== 162) begin errors++; $display("FAIL multi_frame_done got %0d@%0d exp 1@162", r_fdone, r_fd_beat); end
    checks++; if (r_gen_bad !== 0 || r_lat_bad !== 0) begin errors++; $display("FAIL multi_gen_en got %0d/%0d exp 0/0", r_gen_bad, r_lat_bad); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL multi_err got %0d exp 0", err); end
  endtask

  task automatic test_early_done;
    m_steps = 16; force_after = 10;
    run_frame(2'd0, 10'd1, 1'b0, 1);
    checks++; if (r_beats !== 16 || r_fdone !== 1) begin errors++; $display("FAIL early_seq got %0d/%0d exp 16/1", r_beats, r_fdone); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL early_err got %0d exp 1", err); end
    @(posedge clk); @(posedge clk); #2;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL early_err_sticky got %0d exp 1", err); end
    force_after = -1;
    @(posedge clk); #1; image_resolution = 2'd0; num_masks = 10'd1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; #1;
    checks++; if (err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL early_err_clear got %0d/%0d exp 0/1", err, busy); end
    abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
  endtask

  task automatic test_missing_done;
    m_steps = 16; auto_done = 1'b0;
    run_frame(2'd0, 10'd1, 1'b0, 1);
    checks++; if (r_beats !== 16 || err !== 1'b0) begin errors++; $display("FAIL missing_pre got %0d/%0d exp 16/0", r_beats, err); end
    @(posedge clk); @(posedge clk); #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL missing_err got %0d exp 1", err); end
    auto_done = 1'b1;
  endtask

  task automatic test_abort;
    int beats, fd, gcnt;
    beats = 0; fd = 0; gcnt = 0;
    m_steps = 32;
    @(posedge clk); #1; image_resolution = 2'd1; num_masks = 10'd2; start = 1'b1;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      gcnt = gen_en ? gcnt + 1 : 0;
      gen_valid = gen_en && (gcnt >= 1);
      #1;
      if (ser_next) beats++;
      if (frame_done) fd++;
      if (beats == 52) break;
    end
    gen_valid = 1'b0;
    checks++; if (beats !== 52) begin errors++; $display("FAIL abort_reach got %0d exp 52", beats); end
    @(posedge clk); #1; abort = 1'b1; start = 1'b1; #1;
    if (frame_done) fd++;
    @(posedge clk); #1; abort = 1'b0; start = 1'b0; #1;
    checks++; if ({busy, gen_en, ser_load, ser_next, frame_done} !== 5'b0) begin errors++; $display("FAIL abort_idle got %b exp 00000", {busy, gen_en, ser_load, ser_next, frame_done}); end
    checks++; if (mask_idx !== 10'd1 || fd !== 0) begin errors++; $display("FAIL abort_hold got idx %0d fd %0d exp 1 0", mask_idx, fd); end
    @(posedge clk); #2;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_start_ignored got %0d exp 0", busy); end
    run_frame(2'd1, 10'd1, 1'b0, 2);
    checks++; if (r_timeout || r_beats !== 32 || r_fdone !== 1 || err !== 1'b0) begin errors++; $display("FAIL abort_rerun got %0d/%0d/%0d exp 32/1/0", r_beats, r_fdone, err); end
  endtask

  task automatic test_corner;
    m_steps = 32;
    run_frame(2'd3, 10'd0, 1'b0, 1);
    checks++; if (r_timeout || r_beats !== 32 || r_loads !== 1 || r_fdone !== 1) begin errors++; $display("FAIL corner_cfg got %0d/%0d/%0d exp 32/1/1", r_beats, r_loads, r_fdone); end
    @(posedge clk); #1; image_resolution = 2'd1; num_masks = 10'd1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; #1;
    checks++; if (gen_en !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL corner_wait_gen got %0d/%0d exp 1/1", gen_en, busy); end
    @(posedge clk); #3; rst = 1'b1; #1;
    checks++; if ({gen_en, ser_load, ser_next, busy, frame_done, err} !== 6'b0 || mask_idx !== 10'd0) begin errors++; $display("FAIL corner_async_rst got %b exp 000000", {gen_en, ser_load, ser_next, busy, frame_done, err}); end
    #2; rst = 1'b0;
    @(posedge clk); #2;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL corner_post_rst got %0d exp 0", busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi_toggle();
    test_early_done();
    test_missing_done();
    test_abort();
    test_corner();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mask_stream_sequencer.md
Name: mask_stream_sequencer

Overview:
- Controls the mask-generation and serializer datapath for one frame.
- Enables the mask generator, waits for its valid mask, and issues a one-cycle load to the serializer.
- Paces the serializer's `next` strobes against downstream readiness and counts output beats per mask and masks per frame.
- Flags a protocol error if the serializer's done indication disagrees with the beat count expected for the selected resolution.

Parameters:
- OP_CHANNEL_WIDTH, 20, serializer output beat width; used only for documentation and checks.
- STEPS_RES0, 16, beats per mask at resolution 0 (320/OP_CHANNEL_WIDTH).
- STEPS_RES1, 32, beats per mask at resolution 1 (640/OP_CHANNEL_WIDTH).
- STEPS_RES2, 54, beats per mask at resolution 2 (1080/OP_CHANNEL_WIDTH).
- MASK_CNT_W, 10, width of the masks-per-frame counter.

Ports:
- clk  in  1  clock; the block uses this single clock.
- rst  in  1  reset, asynchronous and active-high.
- start  in  1  one-cycle pulse that begins a frame; ignored unless in IDLE.
- abort  in  1  returns to IDLE next cycle from any state.
- num_masks  in  MASK_CNT_W  masks per frame; sampled on start; 0 is treated as 1.
- image_resolution  in  2  resolution select 0/1/2; sampled on start; 3 is treated as 1.
- gen_valid  in  1  mask generator has a valid mask.
- gen_en  out  1  generator enable.
- ser_load  out  1  one-cycle load strobe to the serializer.
- ser_next  out  1  advance serializer by one beat.
- ser_done  in  1  serializer reports its last beat was emitted.
- sink_ready  in  1  downstream accepts a beat this cycle.
- beat_valid  out  1  DOUT beat valid; equals ser_next.
- busy  out  1  high in any state except IDLE.
- frame_done  out  1  one-cycle pulse when the final beat of the frame is accepted.
- mask_idx  out  MASK_CNT_W  index of the current mask.
- err  out  1  sticky error; cleared by start or rst.

Behaviour:
- Reset values: state IDLE; all outputs 0; all counters 0; latched steps = STEPS_RES1.
- **IDLE:** on start, latch num_masks (max(1, num_masks)) and steps (from resolution), clear mask_idx, clear err, go to WAIT_GEN.
- **WAIT_GEN:**
  - gen_en=1.
  - When gen_valid=1, go to LOAD; gen_en drops to 0 in the same cycle the state registers LOAD.
- **LOAD:**
  - ser_load=1 for exactly one cycle.
  - Clear beat_cnt, go to STREAM.
  - Latency from gen_valid to ser_load is 1 cycle.
- **STREAM:**
  - ser_next = beat_valid = sink_ready, combinational from state.
  - Each cycle with ser_next=1 increments beat_cnt.
  - When the accepted beat is the last one (beat_cnt == steps-1 with ser_next=1):
    - If mask_idx == num_masks-1: pulse frame_done, go to IDLE.
    - Otherwise: increment mask_idx, go to WAIT_GEN.
  - sink_ready=0 stalls with no beat counted.
- **Error checks:**
  - ser_done=1 in STREAM before the last accepted beat sets err.
  - No ser_done within 2 cycles after the last beat sets err.
  - ser_done arriving in the same cycle as the last beat is legal.
  - err does not alter sequencing.
- **Control priority and abort:**
  - abort has priority over all transitions, including a simultaneous start.
  - On abort: deassert gen_en, ser_load and ser_next next cycle; mask_idx holds its value; no frame_done is issued.
- **Ignored inputs:**
  - start outside IDLE is ignored.
  - gen_valid outside WAIT_GEN is ignored.
- **Counters:**
  - beat_cnt is 6 bits, wide enough for 54; no wrap occurs because it is cleared in LOAD.
  - mask_idx never exceeds num_masks-1.
- **Reset mid-frame:** immediate IDLE; outputs as at reset.

Decomposition:
- Package mask_seq_pkg holds:
  - state enum seq_state_t {IDLE, WAIT_GEN, LOAD, STREAM};
  - resolution codes RES_320/RES_640/RES_1080;
  - function steps_for_res(res) returning the beat count.
- Sub-module beat_counter (load/clear, enable, terminal-count compare to latched steps, last_beat output) keeps the FSM compact.

Test Plan:
- Single mask at resolution 1, num_masks=1, sink_ready=1, gen_valid raised 3 cycles after start:
  - ser_load 1 cycle after gen_valid;
  - exactly 32 ser_next pulses;
  - frame_done on the 32nd beat;
  - busy falls the next cycle.
- num_masks=3, resolution 2, sink_ready toggling 1/0 every cycle:
  - 54 accepted beats per mask, 162 total;
  - mask_idx 0→1→2;
  - 3 ser_load pulses;
  - gen_en high only in WAIT_GEN.
- ser_done forced high after beat 10 of 16 (resolution 0): err=1 and stays 1; sequencing still completes 16 beats; next start clears err.
- abort asserted mid-STREAM at beat 20 together with start:
  - IDLE next cycle, no frame_done;
  - a subsequent start runs a full frame cleanly.
- Corner configurations:
  - resolution=3, num_masks=0 → behaves as 32 beats, 1 mask.
  - rst pulsed asynchronously mid-WAIT_GEN → all outputs 0 immediately.
